fetch_sequencer: RTL

//  Multi-cycle fetch/sequence FSM for the 16-bit Von Neumann RISC; sits directly upstream of control_unit.

---
 rtl/fetch_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multi-cycle fetch/exec/mem/halt sequencer; optional SEQ_PERF_CNT_EN retired-instruction counter
module fetch_sequencer #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] mem_rdata_in,
  input  logic              mem_ready_in,
  output logic              mem_req_out,
  output logic              mem_addr_sel_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [15:0]       instr_out,
  output logic [3:0]        opcode_out,
  input  logic              mem_access_in,
  input  logic              jump_enable_in,
  input  logic              branch_enable_in,
  input  logic              halt_in,
  input  logic              alu_zero_flag_in,
  output logic              commit_out,
`ifdef SEQ_PERF_CNT_EN
  output logic              halted_out,
  output logic [31:0]       retired_count_out
`else
  output logic              halted_out
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] LP_ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_instr;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_branch_target;
  logic [ADDR_W-1:0] w_jump_target;
  logic              w_exec_retire;
  logic              w_mem_retire;

  // PC arithmetic wraps naturally at ADDR_W bits; the branch offset is relative to the already-incremented PC
  assign w_pc_inc        = r_pc + LP_ONE;
  assign w_branch_target = r_pc + {{(ADDR_W-8){r_instr[7]}}, r_instr[7:0]};

  generate
    if (ADDR_W > 12) begin : g_jump_page
      assign w_jump_target = {r_pc[ADDR_W-1:12], r_instr[11:0]};
    end else begin : g_jump_flat
      assign w_jump_target = r_instr[11:0];
    end
  endgenerate

  // An instruction retires in EXEC unless it halts or needs a data access; LD/ST retire when memory answers
  assign w_exec_retire = (r_state == S_EXEC) && !halt_in && !mem_access_in;
  assign w_mem_retire  = (r_state == S_MEM) && mem_ready_in;

  // Memory request is gated by rst_n so a reset mid-access drops the request immediately
  assign mem_req_out      = rst_n && ((r_state == S_FETCH) || (r_state == S_MEM));
  assign mem_addr_sel_out = (r_state == S_MEM);
  assign halted_out       = (r_state == S_HALT);
  assign commit_out       = w_exec_retire || w_mem_retire;
  assign pc_out           = r_pc;
  assign instr_out        = r_instr;
  assign opcode_out       = r_instr[15:12];

  // Sequencer FSM: owns state, PC and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= LP_RESET_PC;
      r_instr <= 16'h0000;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready_in) begin
            r_instr <= mem_rdata_in[15:0];
            r_pc    <= w_pc_inc;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (halt_in) begin
            r_state <= S_HALT;
          end else if (mem_access_in) begin
            r_state <= S_MEM;
          end else if (jump_enable_in) begin
            r_pc    <= w_jump_target;
            r_state <= S_FETCH;
          end else if (branch_enable_in) begin
            if (alu_zero_flag_in) begin
              r_pc <= w_branch_target;
            end
            r_state <= S_FETCH;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready_in) begin
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_retired_count;

  // Retired-instruction counter; it cannot advance in HALT because commit_out is low there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired_count <= 32'd0;
    end else if (commit_out) begin
      r_retired_count <= r_retired_count + 32'd1;
    end
  end

  assign retired_count_out = r_retired_count;
`endif

endmodule
